// File: rtl/credit_receiver_pkg.sv
// Link constants shared between credit_receiver and the credit sender:
// default link depth and the counter/pointer width formulas.
package credit_receiver_pkg;

    localparam int CREDITS_MAX_DEFAULT = 8;

    // Counters must hold the value CREDITS_MAX itself, hence +1.
    function automatic int cnt_width(input int credits_max);
        return $clog2(credits_max + 1);
    endfunction

    function automatic int ptr_width(input int credits_max);
        return (credits_max > 1) ? $clog2(credits_max) : 1;
    endfunction

endpackage

// File: rtl/credit_fifo_mem.sv
// Register-array storage for the receive buffer: one write port, one
// asynchronous read port, no control logic.
module credit_fifo_mem #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PTR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [PTR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; occupancy is tracked by the control logic,
    // so stale words are never presented as valid and the array stays plain flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/credit_receiver.sv
// Receive side of a credit-based link: buffers pushed words, presents them on a
// valid/ready port and returns one credit per freed slot plus CREDITS_MAX after reset.
module credit_receiver
    import credit_receiver_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CREDITS_MAX = CREDITS_MAX_DEFAULT,
    parameter int PTR_WIDTH   = ptr_width(CREDITS_MAX),
    parameter int CNT_WIDTH   = cnt_width(CREDITS_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             credit,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             overflow
);

    localparam logic [CNT_WIDTH-1:0] FULL     = CNT_WIDTH'(CREDITS_MAX);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(CREDITS_MAX - 1);

    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] pending;
    logic                 full;
    logic                 push;
    logic                 deq;
    logic                 pending_nz;

    // Explicit wrap so depths that are not a power of two work.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    assign full       = (count == FULL);
    assign push       = in_valid && !full;
    assign out_valid  = (count != '0);
    assign deq        = out_valid && out_ready;
    assign pending_nz = (pending != '0);
    // Gate with rst so no credit leaks while the link is held in reset.
    assign credit     = pending_nz && rst;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            pending  <= FULL;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= next_ptr(wptr);
            end
            if (deq) begin
                rptr <= next_ptr(rptr);
            end

            if (push && !deq) begin
                count <= count + CNT_WIDTH'(1);
            end else if (deq && !push) begin
                count <= count - CNT_WIDTH'(1);
            end

            if (deq && !pending_nz) begin
                pending <= pending + CNT_WIDTH'(1);
            end else if (!deq && pending_nz) begin
                pending <= pending - CNT_WIDTH'(1);
            end

            // A push into a full buffer is a sender protocol violation; the word is dropped.
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    credit_fifo_mem #(
        .WIDTH     (WIDTH),
        .DEPTH     (CREDITS_MAX),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wptr),
        .wr_data (in_data),
        .rd_addr (rptr),
        .rd_data (out_data)
    );

endmodule
